wb_queue: RTL
=============

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, number of pending write-back entries (power of two, 2..16).
REQ-002 The block SHALL have the port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1, synchronous active-low reset; reset==0 at a rising edge clears state.
REQ-004 The block SHALL have the ports in_valid, input, 1, and in_ready, output, 1, forming the write-request handshake.
REQ-005 The block SHALL have the ports in_addr, input, 5; in_data, input, 32; in_pc, input, 32: destination register, value and issuing PC.
REQ-006 The block SHALL have the port drain_en, input, 1, permitting the head entry to be written this cycle.
REQ-007 The block SHALL have the ports grf_we, output, 1; grf_a3, output, 5; grf_wd, output, 32; grf_pc, output, 32, driving the register-file write port.
REQ-008 The block SHALL have the ports q_addr, input, 5; q_hit, output, 1; q_data, output, 32, forming the pending-write lookup.
REQ-009 The block SHALL have the ports count, output, clog2(DEPTH)+1; empty, output, 1; full, output, 1, giving occupancy.

Function
REQ-010 A push SHALL occur at a rising edge when in_valid && in_ready; in_ready = !full (no same-cycle pass-through when full).
REQ-011 A push with in_addr==0 SHALL complete the handshake but SHALL NOT allocate an entry.
REQ-012 grf_we SHALL equal drain_en && !empty; grf_a3/grf_wd/grf_pc SHALL show the head entry combinationally; they SHALL be 0 when empty.
REQ-013 A pop SHALL occur at the rising edge where grf_we==1; the register file always accepts.
REQ-014 Entries SHALL drain in strict push order; a pushed entry first appears on grf_* the cycle after acceptance (latency 1).
REQ-015 A simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-016 q_hit SHALL be 1 iff q_addr!=0 and some valid entry has addr==q_addr; q_data SHALL be the data of the newest such entry, else 0.
REQ-017 Lookup SHALL include the head entry even in the cycle it is being popped, and SHALL NOT include the entry being pushed that cycle.
REQ-018 empty SHALL be (count==0); full SHALL be (count==DEPTH).

Reset
REQ-019 With reset==0 at a rising edge, count, head and tail pointers SHALL become 0 and all entry valid flags SHALL clear, overriding any simultaneous push or pop.
REQ-020 After reset: empty=1, full=0, in_ready=1, grf_we=0, grf_a3=0, grf_wd=0, grf_pc=0, q_hit=0, q_data=0.
REQ-021 Reset asserted mid-operation SHALL discard all pending entries without issuing them to grf_*.

Configuration
REQ-022 When macro WBQ_COALESCE_EN is defined, a push whose in_addr matches the newest valid entry SHALL overwrite that entry's data and pc in place (no allocation, count unchanged), unless that entry is the head and is popped in the same cycle, in which case it SHALL allocate normally.
REQ-023 With WBQ_COALESCE_EN defined, in_ready SHALL be !full || (in_valid && tail-match per REQ-022).
REQ-024 Without WBQ_COALESCE_EN, every non-zero push SHALL allocate a new entry, and in_ready SHALL be !full.

Verification
REQ-025 The bench SHALL check reset: after reset, push (5, 0x11) and (6, 0x22) with drain_en=0 -> count=2; drain_en=1 -> grf_a3=5, grf_wd=0x11, then grf_a3=6, grf_wd=0x22, then empty=1.
REQ-026 The bench SHALL check full: push 4 entries with drain_en=0 -> full=1, in_ready=0; a fifth push SHALL be ignored; one drain then re-push SHALL wrap the pointers, and the order SHALL be preserved.
REQ-027 The bench SHALL check zero-register drops: push (0, 0xDEAD) -> handshake completes, count stays 0, grf_we stays 0.
REQ-028 The bench SHALL check lookup order: push (7, 0xA) then (7, 0xB) -> q_addr=7 gives q_hit=1, q_data=0xB (without the macro count=2; with WBQ_COALESCE_EN count=1); q_addr=0 gives q_hit=0.
REQ-029 The bench SHALL check reset mid-stream: with 3 entries queued and drain_en=1, drive reset=0 for one edge -> count=0, grf_we=0 the next cycle, and no further writes are issued.
REQ-030 The bench SHALL check a simultaneous push and pop at count=2 -> count stays 2, and the head advances to the next entry.

Source files
------------

// File: rtl/wb_queue.sv
// In-order write-back queue feeding the register-file write port, with a pending-write lookup.
// Define WBQ_COALESCE_EN to merge a push into the newest entry when the destination matches.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_addr,
  input  logic [31:0]              in_data,
  input  logic [31:0]              in_pc,
  input  logic                     drain_en,
  output logic                     grf_we,
  output logic [4:0]               grf_a3,
  output logic [31:0]              grf_wd,
  output logic [31:0]              grf_pc,
  input  logic [4:0]               q_addr,
  output logic                     q_hit,
  output logic [31:0]              q_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      pc_q   [DEPTH];

  logic [PW-1:0] newest;
  logic [PW-1:0] idx;
  logic          pop;
  logic          push;
  logic          alloc;
  logic          merge;
  logic          tail_match;

  assign count  = cnt_q;
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(DEPTH));
  assign newest = tail_q - PW'(1);
  assign pop    = drain_en && !empty;

`ifdef WBQ_COALESCE_EN
  // Merging into the head while it leaves would lose the write.
  assign tail_match = (in_addr != 5'd0) && !empty
                   && (addr_q[newest] == in_addr)
                   && !(pop && (cnt_q == CW'(1)));
  assign in_ready   = !full || (in_valid && tail_match);
`else
  assign tail_match = 1'b0;
  assign in_ready   = !full;
`endif

  assign push  = in_valid && in_ready;
  assign merge = push && tail_match;
  assign alloc = push && (in_addr != 5'd0) && !tail_match;

  assign grf_we = pop;
  assign grf_a3 = empty ? 5'd0  : addr_q[head_q];
  assign grf_wd = empty ? 32'd0 : data_q[head_q];
  assign grf_pc = empty ? 32'd0 : pc_q[head_q];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    if (pop) begin
      head_d        = head_q + PW'(1);
      vld_d[head_q] = 1'b0;
    end
    if (alloc) begin
      tail_d        = tail_q + PW'(1);
      vld_d[tail_q] = 1'b1;
    end
    case ({alloc, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Walk oldest to newest so the last match wins.
  always_comb begin
    q_hit  = 1'b0;
    q_data = 32'd0;
    idx    = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < cnt_q) && vld_q[idx]
          && (q_addr != 5'd0) && (addr_q[idx] == q_addr)) begin
        q_hit  = 1'b1;
        q_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      if (alloc) begin
        addr_q[tail_q] <= in_addr;
        data_q[tail_q] <= in_data;
        pc_q[tail_q]   <= in_pc;
      end
      if (merge) begin
        data_q[newest] <= in_data;
        pc_q[newest]   <= in_pc;
      end
    end
  end

endmodule
